game_score_keeper: RTL and testbench

//  Match controller upstream of the ball FSM. Gates the per-frame go pulse into

---
 rtl/game_score_keeper.sv | 196 +++++++++++++++++++
 tb/tb_game_score_keeper.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_score_keeper.sv
// Match controller for the ball FSM: gates ball_go, keeps both scores, runs the serve pause, declares the winner.
// Optional SCORE_HEX_EN adds registered active-low 7-segment outputs hex_0/hex_1.
module game_score_keeper #(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 50,
  parameter int DLY_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       p0_score_lvl,
  input  logic       p1_score_lvl,
  output logic       ball_go,
  output logic       serve_hold,
  output logic [3:0] score_0,
  output logic [3:0] score_1,
  output logic       game_over,
  output logic       winner,
  output logic [1:0] dbg_state
`ifdef SCORE_HEX_EN
  ,
  output logic [6:0] hex_0,
  output logic [6:0] hex_1
`endif
);

  // dbg_state encoding: 0 IDLE, 1 PLAY, 2 POINT, 3 OVER
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_POINT = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam logic [3:0]       WIN_S    = 4'(WIN_SCORE);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(SERVE_DELAY - 1);
  localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);

  state_t           state_q, state_d;
  logic [3:0]       score_0_q, score_0_d;
  logic [3:0]       score_1_q, score_1_d;
  logic             winner_q, winner_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic             p0_prev_q, p1_prev_q;
  logic             serve_hold_q, game_over_q;

  logic             p0_edge, p1_edge;
  logic             p0_cnt, p1_cnt;
  logic [3:0]       score_0_inc, score_1_inc;

  assign p0_edge = p0_score_lvl & ~p0_prev_q;
  assign p1_edge = p1_score_lvl & ~p1_prev_q;
  // p0 has priority when both players' edges land in the same cycle
  assign p0_cnt  = p0_edge & (state_q == ST_PLAY);
  assign p1_cnt  = p1_edge & ~p0_edge & (state_q == ST_PLAY);

  assign score_0_inc = (score_0_q == WIN_S) ? score_0_q : score_0_q + 4'd1;
  assign score_1_inc = (score_1_q == WIN_S) ? score_1_q : score_1_q + 4'd1;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      score_0_q    <= 4'd0;
      score_1_q    <= 4'd0;
      winner_q     <= 1'b0;
      cnt_q        <= '0;
      p0_prev_q    <= 1'b0;
      p1_prev_q    <= 1'b0;
      serve_hold_q <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_0_q    <= score_0_d;
      score_1_q    <= score_1_d;
      winner_q     <= winner_d;
      cnt_q        <= cnt_d;
      p0_prev_q    <= p0_score_lvl;
      p1_prev_q    <= p1_score_lvl;
      serve_hold_q <= (state_d == ST_POINT);
      game_over_q  <= (state_d == ST_OVER);
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    score_0_d = score_0_q;
    score_1_d = score_1_q;
    winner_d  = winner_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_PLAY;
          score_0_d = 4'd0;
          score_1_d = 4'd0;
        end
      end
      ST_PLAY: begin
        if (p0_cnt) begin
          score_0_d = score_0_inc;
          if (score_0_inc == WIN_S) begin
            state_d  = ST_OVER;
            winner_d = 1'b0;
          end else begin
            state_d = ST_POINT;
            cnt_d   = '0;
          end
        end else if (p1_cnt) begin
          score_1_d = score_1_inc;
          if (score_1_inc == WIN_S) begin
            state_d  = ST_OVER;
            winner_d = 1'b1;
          end else begin
            state_d = ST_POINT;
            cnt_d   = '0;
          end
        end
      end
      ST_POINT: begin
        if (frame_tick) begin
          if (cnt_q == DLY_LAST) begin
            state_d = ST_PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + DLY_ONE;
          end
        end
      end
      ST_OVER: begin
        if (start) begin
          state_d   = ST_PLAY;
          score_0_d = 4'd0;
          score_1_d = 4'd0;
          winner_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ball_go    = frame_tick & (state_q == ST_PLAY);
    serve_hold = serve_hold_q;
    game_over  = game_over_q;
    winner     = winner_q;
    score_0    = score_0_q;
    score_1    = score_1_q;
    dbg_state  = state_q;
  end

`ifdef SCORE_HEX_EN
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [6:0] hex_0_q, hex_1_q;

  // Decoded from the score registers, so the digits trail the score by one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex_0_q <= 7'b1000000;
      hex_1_q <= 7'b1000000;
    end else begin
      hex_0_q <= seg7(score_0_q);
      hex_1_q <= seg7(score_1_q);
    end
  end

  assign hex_0 = hex_0_q;
  assign hex_1 = hex_1_q;
`endif

endmodule

// File: tb/tb_game_score_keeper.sv
// Bench for game_score_keeper (WIN_SCORE=3, SERVE_DELAY=2): directed scenarios plus random traffic
// against a point-by-point match model; hex outputs are covered when SCORE_HEX_EN is defined.
module tb_game_score_keeper;
  localparam int WIN = 3;
  localparam int SD  = 2;
  localparam int M_IDLE = 0, M_PLAY = 1, M_POINT = 2, M_OVER = 3;

  logic clk = 1'b0;
  logic reset, start, frame_tick, p0, p1;
  logic ball_go, serve_hold, game_over, winner;
  logic [3:0] score_0, score_1;
  logic [1:0] dbg_state;
`ifdef SCORE_HEX_EN
  logic [6:0] hex_0, hex_1;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Clock / reset
  always #5 clk = ~clk;

  game_score_keeper #(.WIN_SCORE(WIN), .SERVE_DELAY(SD), .DLY_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick),
    .p0_score_lvl(p0), .p1_score_lvl(p1),
    .ball_go(ball_go), .serve_hold(serve_hold),
    .score_0(score_0), .score_1(score_1),
    .game_over(game_over), .winner(winner), .dbg_state(dbg_state)
`ifdef SCORE_HEX_EN
    , .hex_0(hex_0), .hex_1(hex_1)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg(input int v);
    logic [6:0] tbl [16];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return tbl[v & 15];
  endfunction

  // Match model: mode, scores, winner, frames left in the serve pause
  int m_mode, m_s0, m_s1, m_win, m_left;
  bit m_prev0, m_prev1;
  logic [6:0] m_hex0, m_hex1;

  task automatic model_reset();
    m_mode = M_IDLE; m_s0 = 0; m_s1 = 0; m_win = 0; m_left = 0;
    m_prev0 = 1'b0; m_prev1 = 1'b0;
    m_hex0 = seg(0); m_hex1 = seg(0);
  endtask

  task automatic model_step();
    bit e0, e1;
    e0 = p0 && !m_prev0;
    e1 = p1 && !m_prev1;
    m_prev0 = p0;
    m_prev1 = p1;
    m_hex0 = seg(m_s0);
    m_hex1 = seg(m_s1);
    case (m_mode)
      M_IDLE: if (start) begin m_mode = M_PLAY; m_s0 = 0; m_s1 = 0; end
      M_PLAY: begin
        if (e0) begin
          m_s0++;
          if (m_s0 == WIN) begin m_mode = M_OVER; m_win = 0; end
          else begin m_mode = M_POINT; m_left = SD; end
        end else if (e1) begin
          m_s1++;
          if (m_s1 == WIN) begin m_mode = M_OVER; m_win = 1; end
          else begin m_mode = M_POINT; m_left = SD; end
        end
      end
      M_POINT: if (frame_tick) begin
        m_left--;
        if (m_left == 0) m_mode = M_PLAY;
      end
      M_OVER: if (start) begin m_mode = M_PLAY; m_s0 = 0; m_s1 = 0; m_win = 0; end
      default: m_mode = M_IDLE;
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // Scoreboard compare every cycle, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && reset === 1'b0) begin
        chk("score_0", score_0, m_s0);
        chk("score_1", score_1, m_s1);
        chk("serve_hold", serve_hold, m_mode == M_POINT);
        chk("game_over", game_over, m_mode == M_OVER);
        chk("winner", winner, m_win);
        chk("state", dbg_state, m_mode);
        chk("ball_go", ball_go, frame_tick && m_mode == M_PLAY);
`ifdef SCORE_HEX_EN
        chk("hex_0", hex_0, m_hex0);
        chk("hex_1", hex_1, m_hex1);
`endif
      end
    end
  end

  // Drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_play();
    int g;
    g = 0;
    while (serve_hold && g < 64) begin
      frame_tick = (g % 2 == 0);
      g++;
      step();
    end
    frame_tick = 1'b0;
    chk("pause_timeout", serve_hold, 0);
  endtask

  initial begin
    int ticks;
    int g;
    reset = 1'b1; start = 1'b0; frame_tick = 1'b0; p0 = 1'b0; p1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_score_0", score_0, 0);
    chk("rst_score_1", score_1, 0);
    chk("rst_serve_hold", serve_hold, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_winner", winner, 0);
    chk("rst_ball_go", ball_go, 0);
    chk("rst_state", dbg_state, M_IDLE);
    reset = 1'b0;
    chk_en = 1'b1;

    // 1: start, then frame ticks every 4 cycles
    start = 1'b1; step(); start = 1'b0;
    chk("t1_state", dbg_state, M_PLAY);
    for (int i = 0; i < 12; i++) begin
      frame_tick = (i % 4 == 0);
      #1;
      chk("t1_ball_go", ball_go, frame_tick);
      step();
    end
    frame_tick = 1'b0;

    // 2: p0 level held high, counts once, pause lasts SD ticks
    p0 = 1'b1; step();
    chk("t2_score_0", score_0, 1);
    chk("t2_serve_hold", serve_hold, 1);
    ticks = 0; g = 0;
    while (serve_hold && g < 40) begin
      frame_tick = (g % 4 == 0);
      if (frame_tick) ticks++;
      g++;
      step();
    end
    frame_tick = 1'b0;
    chk("t2_pause_ticks", ticks, SD);
    repeat (3) step();
    chk("t2_held_once", score_0, 1);
    frame_tick = 1'b1; #1;
    chk("t2_ball_go_resumes", ball_go, 1);
    step(); frame_tick = 1'b0;
    p0 = 1'b0; step();

    // 3: both players in the same cycle
    p0 = 1'b1; p1 = 1'b1; step();
    chk("t3_score_0", score_0, 2);
    chk("t3_score_1", score_1, 0);
    wait_play();
    p0 = 1'b0; p1 = 1'b0; step();

    // 4: p1 wins
    for (int k = 0; k < 3; k++) begin
      p1 = 1'b1; step(); p1 = 1'b0; step();
      if (k < 2) wait_play();
    end
    chk("t4_game_over", game_over, 1);
    chk("t4_winner", winner, 1);
    chk("t4_score_1", score_1, 3);
    frame_tick = 1'b1; #1;
    chk("t4_no_ball_go", ball_go, 0);
    step(); frame_tick = 1'b0;
    p0 = 1'b1; p1 = 1'b1; step(); p0 = 1'b0; p1 = 1'b0; step();
    chk("t4_ignored_0", score_0, 2);
    chk("t4_ignored_1", score_1, 3);
    start = 1'b1; step(); start = 1'b0;
    chk("t4_restart_s0", score_0, 0);
    chk("t4_restart_go", game_over, 0);
    chk("t4_restart_state", dbg_state, M_PLAY);

    // 5: reset mid-pause
    p0 = 1'b1; step(); p0 = 1'b0;
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    chk("t5_mid_pause", serve_hold, 1);
    #2 reset = 1'b1;
    #1;
    chk("t5_serve_hold", serve_hold, 0);
    chk("t5_score_0", score_0, 0);
    chk("t5_state", dbg_state, M_IDLE);
    chk("t5_game_over", game_over, 0);
    @(posedge clk); #1;
    reset = 1'b0;

`ifdef SCORE_HEX_EN
    // 6: hex digit for score 2
    chk("t6_hex_rst", hex_0, 7'b1000000);
    start = 1'b1; step(); start = 1'b0;
    p0 = 1'b1; step(); p0 = 1'b0;
    wait_play();
    p0 = 1'b1; step(); p0 = 1'b0;
    chk("t6_score_0", score_0, 2);
    step();
    chk("t6_hex_0", hex_0, 7'b0100100);
    chk("t6_hex_1", hex_1, 7'b1000000);
    wait_play();
`endif

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      start      = ($urandom_range(0, 15) == 0);
      frame_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 5) == 0) p0 = ~p0;
      if ($urandom_range(0, 5) == 0) p1 = ~p1;
      reset      = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0; start = 1'b0; frame_tick = 1'b0;
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
